pfpu_dest_pipe: RTL and testbench
=================================

PFPU_DEST_PIPE -- requirements
Module: pfpu_dest_pipe

Interface
REQ-001 SHALL have ports sys_clk (in, 1): the only clock; all state updates on its rising edge.
REQ-002 SHALL have ports sys_rst_n (in, 1): asynchronous, active-low reset.
REQ-003 SHALL have ports flush (in, 1): synchronous clear of all in-flight entries, driven with the ALU reset.
REQ-004 SHALL have ports issue (in, 1): an instruction enters the ALU this cycle.
REQ-005 SHALL have ports opcode (in, 4): ALU opcode of the issued instruction.
REQ-006 SHALL have ports dest (in, 7): destination register index of the issued instruction.
REQ-007 SHALL have ports wb_en (out, 1): register-file write enable, aligned with the ALU result.
REQ-008 SHALL have ports wb_addr (out, 7): write address, valid when wb_en=1.
REQ-009 SHALL have ports err_collision (out, 1): one-cycle pulse on a writeback slot conflict.
REQ-010 SHALL have ports busy (out, 1): at least one entry is in flight or wb_en=1.
REQ-011 SHALL have ports rd_a and rd_b (in, 7 each) and hazard (out, 1), per REQ-027.

Function
REQ-012 SHALL map opcode to latency L as follows: 1,2 -> 5; 3 -> 6; 4 -> 5; 5 -> 2; 6 -> 3; 7 -> 2; 8,9 -> 4; A-F -> 2.
REQ-013 SHALL ignore opcode 0 (NOP); no entry is created even when issue=1.
REQ-014 SHALL hold entries in a 6-slot delay line; each slot holds valid plus a 7-bit address; slot k means k+1 edges remain before writeback.
REQ-015 SHALL shift every slot down by one on each edge; slot 0 loads the wb_en/wb_addr registers.
REQ-016 SHALL, for an issue sampled at edge E0 with latency L, assert wb_en with wb_addr=dest for exactly the one cycle following edge E_L.
REQ-017 SHALL write a new entry into slot L-1 after the shift is applied.
REQ-018 SHALL, when the target slot is already valid after the shift, keep the existing entry, drop the new one, and pulse err_collision in the cycle after E0.
REQ-019 SHALL hold wb_addr at its previous value when wb_en=0.
REQ-020 SHALL sustain back-to-back issues every cycle with no stall when latencies do not collide.
REQ-021 SHALL give flush priority over an issue in the same cycle: the issue is dropped, all slots and wb_en clear at that edge, and err_collision stays 0.
REQ-022 SHALL derive busy combinationally: OR of all slot valid bits and wb_en.

Reset
REQ-023 SHALL, while sys_rst_n=0, immediately force all slot valid bits, wb_en, and err_collision to 0, wb_addr to 0, and hazard to 0.
REQ-024 SHALL discard all in-flight entries when reset asserts mid-operation; no writeback occurs for them after release.
REQ-025 SHALL accept an issue on the first rising edge after sys_rst_n deasserts.

Configuration
REQ-026 SHALL use macro PFPU_DEST_PIPE_HAZARD_EN to select read-after-write hazard detection.
REQ-027 SHALL, with PFPU_DEST_PIPE_HAZARD_EN defined, drive hazard=1 combinationally when rd_a or rd_b equals the address of any valid slot or of wb_addr while wb_en=1.
REQ-028 SHALL, with PFPU_DEST_PIPE_HAZARD_EN defined, treat hazard as informational only: it never blocks an entry, and the sequencer stalls on it.
REQ-029 SHALL, without PFPU_DEST_PIPE_HAZARD_EN, tie hazard to 0, leave rd_a and rd_b unused, and keep ports unchanged.

Verification
REQ-030 SHALL check: issue opcode 1 with dest 0x12 at E0 -> wb_en=1 and wb_addr=0x12 only in the cycle after E5; busy falls after E6.
REQ-031 SHALL check: issue opcode 3 (dest 0x05) at E0, then opcode 5 (dest 0x06) at E1 -> writebacks after E3 (0x06) and after E6 (0x05); no error.
REQ-032 SHALL check: issue opcode 1 (dest 0x10) at E0, then opcode 8 (dest 0x11) at E1 -> both land after E5; err_collision pulses after E1; only 0x10 is written.
REQ-033 SHALL check: issue opcode 0 with dest 0x7F -> wb_en, busy, and err_collision all stay 0 for 8 cycles.
REQ-034 SHALL check: issue opcode 3 at E0, then flush and issue opcode 5 together at E2 -> no wb_en for 10 cycles and busy=0 after E2.
REQ-035 SHALL check: with PFPU_DEST_PIPE_HAZARD_EN defined, issue dest 0x20 with opcode 6 and rd_a=0x20 -> hazard=1 from E0 through the writeback cycle after E3, then 0; without the macro, hazard stays 0.

Source files
------------

// File: rtl/pfpu_dest_pipe_if.sv
// Issue/writeback bundle between the PFPU sequencer and the destination-tracking pipe.
// The sequencer drives the issue side; the pipe returns the aligned register-file write.
interface pfpu_dest_pipe_if;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned ADDR_W = 7;

    logic              issue;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] dest;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;

    modport master (output issue, opcode, dest, input  wb_en, wb_addr);
    modport slave  (input  issue, opcode, dest, output wb_en, wb_addr);
endinterface

// File: rtl/pfpu_dest_pipe.sv
// Destination-register delay line that aligns register-file writes with PFPU ALU results.
// Optional RAW hazard detection is enabled by defining PFPU_DEST_PIPE_HAZARD_EN.
module pfpu_dest_pipe (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 flush,
    input  logic [6:0]           rd_a,
    input  logic [6:0]           rd_b,
    output logic                 err_collision,
    output logic                 busy,
    output logic                 hazard,
    pfpu_dest_pipe_if.slave      bus
);
    localparam int unsigned OP_W   = 4;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DEPTH  = 6;
    localparam int unsigned IDX_W  = 3;

    logic [DEPTH-1:0]             slot_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] slot_addr;
    logic [DEPTH-1:0]             vld_nxt;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_nxt;
    logic                         coll_nxt;
    logic [IDX_W-1:0]             lat;
    logic [IDX_W-1:0]             tgt;

    // ALU latency per opcode; NOP returns 0 and never creates an entry
    function automatic logic [IDX_W-1:0] lat_of(input logic [OP_W-1:0] op);
        logic [IDX_W-1:0] l;
        case (op)
            4'h0:             l = 3'd0;
            4'h1, 4'h2, 4'h4: l = 3'd5;
            4'h3:             l = 3'd6;
            4'h6:             l = 3'd3;
            4'h8, 4'h9:       l = 3'd4;
            default:          l = 3'd2;
        endcase
        return l;
    endfunction

    // Shift the line down one slot, then drop the new entry into slot L-1 unless occupied
    always_comb begin
        vld_nxt  = {1'b0, slot_vld[DEPTH-1:1]};
        addr_nxt = {ADDR_W'(0), slot_addr[DEPTH-1:1]};
        coll_nxt = 1'b0;
        lat      = lat_of(bus.opcode);
        tgt      = IDX_W'(lat - 3'd1);
        if (bus.issue && (bus.opcode != 4'h0)) begin
            if (vld_nxt[tgt]) begin
                coll_nxt = 1'b1;
            end else begin
                vld_nxt[tgt]  = 1'b1;
                addr_nxt[tgt] = bus.dest;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slot_vld      <= '0;
            slot_addr     <= '0;
            bus.wb_en     <= 1'b0;
            bus.wb_addr   <= '0;
            err_collision <= 1'b0;
        end else if (flush) begin
            slot_vld      <= '0;
            bus.wb_en     <= 1'b0;
            err_collision <= 1'b0;
        end else begin
            slot_vld      <= vld_nxt;
            slot_addr     <= addr_nxt;
            bus.wb_en     <= slot_vld[0];
            err_collision <= coll_nxt;
            if (slot_vld[0]) begin
                bus.wb_addr <= slot_addr[0];
            end
        end
    end

    assign busy = (|slot_vld) | bus.wb_en;

`ifdef PFPU_DEST_PIPE_HAZARD_EN
    // Flag a read of any register still waiting for (or receiving) its result
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (slot_vld[k] && ((slot_addr[k] == rd_a) || (slot_addr[k] == rd_b))) begin
                hazard = 1'b1;
            end
        end
        if (bus.wb_en && ((bus.wb_addr == rd_a) || (bus.wb_addr == rd_b))) begin
            hazard = 1'b1;
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^{rd_a, rd_b};
    assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_pfpu_dest_pipe.sv
// Self-checking bench for pfpu_dest_pipe: directed scenarios plus random traffic
// compared against a landing-time scoreboard model.
module tb_pfpu_dest_pipe;
    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [6:0] rd_a = 7'h00;
    logic [6:0] rd_b = 7'h00;
    logic       err_collision;
    logic       busy;
    logic       hazard;

    pfpu_dest_pipe_if bus ();

    pfpu_dest_pipe dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .flush         (flush),
        .rd_a          (rd_a),
        .rd_b          (rd_b),
        .err_collision (err_collision),
        .busy          (busy),
        .hazard        (hazard),
        .bus           (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending writes keyed by the absolute edge on which they land
    int         lat_tab [16] = '{0, 5, 5, 6, 5, 2, 3, 2, 4, 4, 2, 2, 2, 2, 2, 2};
    logic [6:0] pend [int];
    int         edge_no = 0;
    logic       m_wb_en = 1'b0;
    logic [6:0] m_wb_addr = 7'h00;
    logic       m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic exp_busy();
        return (pend.num() > 0) || m_wb_en;
    endfunction

    function automatic logic exp_hazard();
        logic h = 1'b0;
`ifdef PFPU_DEST_PIPE_HAZARD_EN
        foreach (pend[k]) begin
            if (pend[k] == rd_a || pend[k] == rd_b) h = 1'b1;
        end
        if (m_wb_en && (m_wb_addr == rd_a || m_wb_addr == rd_b)) h = 1'b1;
`endif
        return h;
    endfunction

    task automatic model_edge();
        edge_no++;
        if (flush) begin
            pend.delete();
            m_wb_en = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_err = 1'b0;
            if (pend.exists(edge_no)) begin
                m_wb_en   = 1'b1;
                m_wb_addr = pend[edge_no];
                pend.delete(edge_no);
            end else begin
                m_wb_en = 1'b0;
            end
            if (bus.issue && bus.opcode != 4'h0) begin
                int t = edge_no + lat_tab[bus.opcode];
                if (pend.exists(t)) m_err = 1'b1;
                else                pend[t] = bus.dest;
            end
        end
    endtask

    task automatic check_outputs(input string where);
        check({where, ".wb_en"},   32'(bus.wb_en),   32'(m_wb_en));
        check({where, ".wb_addr"}, 32'(bus.wb_addr), 32'(m_wb_addr));
        check({where, ".err"},     32'(err_collision), 32'(m_err));
        check({where, ".busy"},    32'(busy),        32'(exp_busy()));
        check({where, ".hazard"},  32'(hazard),      32'(exp_hazard()));
    endtask

    // One cycle: drive after the falling edge, check combinational outputs, clock, check registers
    task automatic step(input logic iss, input logic [3:0] op, input logic [6:0] d,
                        input logic fl, input logic [6:0] ra, input logic [6:0] rb);
        bus.issue  = iss;
        bus.opcode = op;
        bus.dest   = d;
        flush      = fl;
        rd_a       = ra;
        rd_b       = rb;
        #1;
        check("pre.hazard", 32'(hazard), 32'(exp_hazard()));
        check("pre.busy",   32'(busy),   32'(exp_busy()));
        @(posedge sys_clk);
        model_edge();
        #1;
        check_outputs("post");
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n, input logic [6:0] ra);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 7'h00, 1'b0, ra, 7'h7E);
    endtask

    task automatic do_reset();
        #2;
        sys_rst_n = 1'b0;
        pend.delete();
        m_wb_en   = 1'b0;
        m_wb_addr = 7'h00;
        m_err     = 1'b0;
        #1;
        check_outputs("reset");
        @(negedge sys_clk);
        @(negedge sys_clk);
        check_outputs("reset_hold");
        sys_rst_n = 1'b1;
    endtask

    initial begin
        bus.issue  = 1'b0;
        bus.opcode = 4'h0;
        bus.dest   = 7'h00;
        #1;
        check_outputs("reset0");
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // single op1 writeback after E5 (issue on first edge after reset release)
        step(1'b1, 4'h1, 7'h12, 1'b0, 7'h00, 7'h7E);
        idle(8, 7'h00);
        // op3 then op5: writebacks out of issue order, no error
        step(1'b1, 4'h3, 7'h05, 1'b0, 7'h00, 7'h7E);
        step(1'b1, 4'h5, 7'h06, 1'b0, 7'h00, 7'h7E);
        idle(8, 7'h00);
        // op1 then op8 land on the same edge: second one dropped
        step(1'b1, 4'h1, 7'h10, 1'b0, 7'h00, 7'h7E);
        step(1'b1, 4'h8, 7'h11, 1'b0, 7'h00, 7'h7E);
        idle(8, 7'h00);
        // NOP never creates an entry
        step(1'b1, 4'h0, 7'h7F, 1'b0, 7'h00, 7'h7E);
        idle(8, 7'h00);
        // flush wins over a same-cycle issue
        step(1'b1, 4'h3, 7'h22, 1'b0, 7'h00, 7'h7E);
        idle(1, 7'h00);
        step(1'b1, 4'h5, 7'h23, 1'b1, 7'h00, 7'h7E);
        idle(10, 7'h00);
        // read of a pending destination
        step(1'b1, 4'h6, 7'h20, 1'b0, 7'h20, 7'h7E);
        idle(6, 7'h20);
        // reset in mid-flight discards entries
        step(1'b1, 4'h3, 7'h31, 1'b0, 7'h31, 7'h7E);
        step(1'b1, 4'h9, 7'h32, 1'b0, 7'h31, 7'h32);
        do_reset();
        step(1'b1, 4'h7, 7'h33, 1'b0, 7'h33, 7'h31);
        idle(8, 7'h31);

        // random traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] ra, rb, d;
            d  = 7'($urandom_range(0, 15)) + 7'h40;
            ra = 7'($urandom_range(0, 15)) + 7'h40;
            rb = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 15)) + 7'h40;
            step(1'($urandom_range(0, 3) != 0), 4'($urandom), d,
                 1'($urandom_range(0, 40) == 0), ra, rb);
            if ($urandom_range(0, 300) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
